// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the neural-network sample loader.
package nn_pkg;
   localparam int DW         = 8;
   localparam int N          = 62;
   localparam int FEAT_BUS_W = N * DW;

   localparam logic [7:0] CLASS_TIMEOUT = 8'hFF;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      START  = 2'd1,
      WAIT   = 2'd2,
      RESULT = 2'd3
   } state_t;
endpackage

// File: rtl/nn_byte_deser.sv
// Byte deserializer: writes each accepted byte into its DW-wide slot of the
// flat sample bus and pulses done alongside the last byte of a sample.
module nn_byte_deser #(
   parameter int DW = nn_pkg::DW,
   parameter int N  = nn_pkg::N
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [DW-1:0]   data,
   output logic [N*DW-1:0] bus,
   output logic            done
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [IW-1:0] idx_r;
   logic          last_s;

   assign last_s = (idx_r == LAST);
   assign done   = en && last_s;

   // Feature index counter and slice write into the sample bus.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_r <= '0;
         bus   <= '0;
      end else if (en) begin
         bus[idx_r*DW +: DW] <= data;
         idx_r               <= last_s ? '0 : idx_r + 1'b1;
      end
   end
endmodule

// File: rtl/nn_sample_loader.sv
// Sample loader: assembles a byte-streamed sample, starts the NN datapath,
// captures its class result (or a timeout) and hands it to the consumer.
module nn_sample_loader #(
   parameter int DW       = nn_pkg::DW,
   parameter int N        = nn_pkg::N,
   parameter int MAX_WAIT = 1024,
   parameter int CW       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [DW-1:0]   in_data,
   output logic            in_ready,
   output logic [N*DW-1:0] test_data,
   output logic            nn_start,
   input  logic            nn_ready,
   input  logic [7:0]      test_out,
   output logic            res_valid,
   output logic [7:0]      res_class,
   output logic            res_err,
   input  logic            res_ready,
   output logic [CW-1:0]   sample_count
);
   import nn_pkg::*;

   localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

   state_t         state_r;
   state_t         state_s;
   logic [WCW-1:0] wait_cnt_r;
   logic           nn_ready_q_r;
   logic           in_ready_r;
   logic           nn_start_r;
   logic           res_valid_r;
   logic           res_err_r;
   logic [7:0]     res_class_r;
   logic [CW-1:0]  sample_count_r;
   logic           accept_s;
   logic           done_s;
   logic           edge_s;
   logic           timeout_s;

   assign accept_s  = in_valid && in_ready_r;
   // Only a genuine low-to-high transition counts, so a ready left high by a
   // previous run is never mistaken for a fresh result.
   assign edge_s    = nn_ready && !nn_ready_q_r;
   assign timeout_s = (wait_cnt_r == WAIT_LAST);

   nn_byte_deser #(
      .DW (DW),
      .N  (N)
   ) u_deser (
      .clk  (clk),
      .rst  (rst),
      .en   (accept_s),
      .data (in_data),
      .bus  (test_data),
      .done (done_s)
   );

   // Next-state decode; an edge and a timeout in the same cycle both lead to RESULT.
   always_comb begin
      state_s = state_r;
      case (state_r)
         LOAD: begin
            if (done_s) state_s = START;
            else        state_s = LOAD;
         end
         START:  state_s = WAIT;
         WAIT: begin
            if (edge_s || timeout_s) state_s = RESULT;
            else                     state_s = WAIT;
         end
         RESULT: begin
            if (res_ready) state_s = LOAD;
            else           state_s = RESULT;
         end
         default: state_s = LOAD;
      endcase
   end

   // State register, registered handshake outputs, wait timer and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= LOAD;
         wait_cnt_r     <= '0;
         nn_ready_q_r   <= 1'b1;
         in_ready_r     <= 1'b1;
         nn_start_r     <= 1'b0;
         res_valid_r    <= 1'b0;
         res_err_r      <= 1'b0;
         res_class_r    <= 8'h00;
         sample_count_r <= '0;
      end else begin
         state_r      <= state_s;
         nn_ready_q_r <= nn_ready;
         in_ready_r   <= (state_s == LOAD);
         nn_start_r   <= (state_s == START);
         res_valid_r  <= (state_s == RESULT);
         if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + 1'b1;
         else                 wait_cnt_r <= '0;
         if ((state_r == WAIT) && edge_s) begin
            res_class_r <= test_out;
            res_err_r   <= 1'b0;
         end else if ((state_r == WAIT) && timeout_s) begin
            res_class_r <= CLASS_TIMEOUT;
            res_err_r   <= 1'b1;
         end
         if ((state_r == RESULT) && res_ready) sample_count_r <= sample_count_r + 1'b1;
      end
   end

   assign in_ready     = in_ready_r;
   assign nn_start     = nn_start_r;
   assign res_valid    = res_valid_r;
   assign res_class    = res_class_r;
   assign res_err      = res_err_r;
   assign sample_count = sample_count_r;
endmodule

// File: tb/tb_nn_sample_loader.sv
// Directed bench for nn_sample_loader: a table of sample transactions plus
// hand-written reset sequences, all expectations computed here.
module tb_nn_sample_loader;
   import nn_pkg::*;

   localparam int TDW = N * DW;
   localparam int MW  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [DW-1:0]  in_data;
   logic           in_ready;
   logic [TDW-1:0] test_data;
   logic           nn_start;
   logic           nn_ready;
   logic [7:0]     test_out;
   logic           res_valid;
   logic [7:0]     res_class;
   logic           res_err;
   logic           res_ready;
   logic [15:0]    sample_count;

   always #5 clk = ~clk;

   nn_sample_loader #(
      .DW       (DW),
      .N        (N),
      .MAX_WAIT (MW),
      .CW       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .test_data    (test_data),
      .nn_start     (nn_start),
      .nn_ready     (nn_ready),
      .test_out     (test_out),
      .res_valid    (res_valid),
      .res_class    (res_class),
      .res_err      (res_err),
      .res_ready    (res_ready),
      .sample_count (sample_count)
   );

   // pat: byte pattern; d: WAIT cycle at which nn_ready rises (<0: keep load level)
   typedef struct {
      int         pat;
      bit         gaps;
      bit         stale;
      int         d;
      logic [7:0] tout;
      int         rr;
      logic [7:0] ecls;
      bit         eerr;
   } vec_t;

   vec_t           vecs[5];
   int             total = 0;
   int             bad   = 0;
   logic [TDW-1:0] exp_data;
   logic [15:0]    exp_count;

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [7:0] pbyte(input int pat, input int i);
      logic [7:0] b;
      case (pat)
         0:       b = 8'(i + 1);
         1:       b = 8'(i * 7 + 3);
         2:       b = 8'(255 - i);
         default: b = 8'hAA;
      endcase
      return b;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_in_ready"},     in_ready,     1'b1);
      chk({tag, "_nn_start"},     nn_start,     1'b0);
      chk({tag, "_res_valid"},    res_valid,    1'b0);
      chk({tag, "_res_err"},      res_err,      1'b0);
      chk({tag, "_res_class"},    res_class,    8'h00);
      chk({tag, "_test_data"},    test_data,    {TDW{1'b0}});
      chk({tag, "_sample_count"}, sample_count, 16'd0);
   endtask

   task automatic load_bytes(input int pat, input int cnt, input bit gaps, input bit stale);
      int i = 0;
      int guard = 0;
      while (i < cnt && guard < 1000) begin
         @(negedge clk);
         guard++;
         nn_ready = stale;
         if (gaps && ($urandom_range(0, 1) == 0)) begin
            in_valid = 1'b0;
            in_data  = 8'h5A;
         end else begin
            chk("in_ready_load", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = pbyte(pat, i);
            exp_data[i*DW +: DW] = in_data;
            i++;
         end
      end
      if (i < cnt) chk("load_bound", 1'b0, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      int got;
      int want_lat;
      load_bytes(v.pat, N, v.gaps, v.stale);
      @(negedge clk);
      chk("nn_start_pulse", nn_start, 1'b1);
      chk("in_ready_start", in_ready, 1'b0);
      chk("test_data_load", test_data, exp_data);
      in_valid = 1'b1;
      in_data  = 8'h55;
      nn_ready = v.stale;
      test_out = v.tout;
      got = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) chk("nn_start_once", nn_start, 1'b0);
         if (res_valid) begin
            got = k;
            break;
         end
         chk("in_ready_wait", in_ready, 1'b0);
         if (v.d >= 0) nn_ready = (k >= v.d);
         in_valid = (k % 2 == 0);
      end
      want_lat = (v.d < 0) ? MW : v.d + 1;
      chk("res_latency", got, want_lat);
      in_valid = 1'b0;
      chk("res_class", res_class, v.ecls);
      chk("res_err", res_err, v.eerr);
      chk("test_data_kept", test_data, exp_data);
      for (int j = 0; j <= v.rr; j++) begin
         if (j > 0) begin
            @(negedge clk);
            chk("res_valid_hold", res_valid, 1'b1);
            chk("res_class_hold", res_class, v.ecls);
         end
         res_ready = (j == v.rr);
      end
      @(negedge clk);
      res_ready = 1'b0;
      exp_count++;
      chk("res_valid_drop", res_valid, 1'b0);
      chk("in_ready_after", in_ready, 1'b1);
      chk("sample_count", sample_count, exp_count);
      chk("res_class_after", res_class, v.ecls);
      chk("res_err_after", res_err, v.eerr);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t aa;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      nn_ready  = 1'b0;
      test_out  = 8'h00;
      res_ready = 1'b0;
      exp_data  = '0;
      exp_count = 16'd0;

      vecs[0] = '{0, 1'b0, 1'b0,  5, 8'd7,  0, 8'd7,  1'b0};
      vecs[1] = '{1, 1'b1, 1'b1,  2, 8'd3, 10, 8'd3,  1'b0};
      vecs[2] = '{2, 1'b0, 1'b0, -1, 8'd9,  2, 8'hFF, 1'b1};
      vecs[3] = '{1, 1'b1, 1'b0, 15, 8'h42, 1, 8'h42, 1'b0};
      vecs[4] = '{0, 1'b0, 1'b1, -1, 8'h11, 0, 8'hFF, 1'b1};

      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Partial sample, then reset: the next sample must start from scratch.
      load_bytes(1, 30, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("midrst");
      exp_data  = '0;
      exp_count = 16'd0;
      aa = '{3, 1'b0, 1'b0, 3, 8'h21, 0, 8'h21, 1'b0};
      run_vec(aa);
      chk("all_aa", test_data, {N{8'hAA}});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
